// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyphs and game-state encoding.
package seg_pkg;

    typedef enum logic [1:0] {
        GS_WELCOME   = 2'b00,
        GS_RUN       = 2'b01,
        GS_GAME_OVER = 2'b10,
        GS_JUMP      = 2'b11
    } game_state_e;

    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Segments g..a, active-low; codes 10..15 are not BCD and show a dash.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, GLYPH_DASH, GLYPH_DASH,
        GLYPH_DASH, GLYPH_DASH, GLYPH_DASH, GLYPH_DASH
    };

endpackage

// File: rtl/seg_decode.sv
// Combinational 4-bit value to active-low seven-segment glyph.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    assign glyph = GLYPH_TABLE[value];

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment driver with frame snapshot, level DP and game-over blink.
// Optional leading-zero blanking is enabled with the SEG_LZB_EN macro.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] num3_disp,
    input  logic [3:0] num2_disp,
    input  logic [3:0] num1_disp,
    input  logic [3:0] num0_disp,
    input  logic [1:0] level,
    input  logic [2:0] game_state,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SC_W-1:0]      sc_q, sc_d;
    logic [1:0]           di_q, di_d;
    logic [FC_W-1:0]      fc_q, fc_d;
    logic                 bp_q, bp_d;
    logic [3:0][3:0]      snap_q, snap_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;

    logic                 sc_wrap, frame_wrap, fc_wrap;
    logic [6:0]           glyph;
    logic                 dp_hit, blank_slot, blink_off;
    logic                 unused_gs;

    assign unused_gs = game_state[2];

    seg_decode u_decode (
        .value (snap_q[di_q]),
        .glyph (glyph)
    );

    always_comb begin
        sc_wrap    = (sc_q == SC_W'(SCAN_DIV - 1));
        frame_wrap = sc_wrap && (di_q == 2'd3);
        fc_wrap    = frame_wrap && (fc_q == FC_W'(BLINK_FRAMES - 1));

        sc_d   = sc_wrap ? '0 : sc_q + SC_W'(1);
        di_d   = sc_wrap ? di_q + 2'd1 : di_q;
        snap_d = frame_wrap ? {num3_disp, num2_disp, num1_disp, num0_disp} : snap_q;
        fc_d   = frame_wrap ? (fc_wrap ? '0 : fc_q + FC_W'(1)) : fc_q;
        bp_d   = fc_wrap ? ~bp_q : bp_q;
    end

    always_comb begin
        dp_hit     = (di_q == level);
        blink_off  = (game_state[1:0] == GS_GAME_OVER) && !bp_q;
        blank_slot = 1'b0;
`ifdef SEG_LZB_EN
        case (di_q)
            2'd3:    blank_slot = (snap_q[3] == 4'd0);
            2'd2:    blank_slot = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0);
            2'd1:    blank_slot = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0) && (snap_q[1] == 4'd0);
            default: blank_slot = 1'b0;
        endcase
`endif

        an_d  = ~(4'b0001 << di_q);
        seg_d = glyph;
        dp_d  = ~dp_hit;

        // A blanked digit still lights its DP when it carries the level marker.
        if (blank_slot) begin
            seg_d = GLYPH_BLANK;
            if (!dp_hit) an_d = 4'b1111;
        end

        if (blink_off) begin
            an_d  = 4'b1111;
            seg_d = GLYPH_BLANK;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sc_q   <= '0;
            di_q   <= 2'd0;
            fc_q   <= '0;
            bp_q   <= 1'b1;
            snap_q <= '0;
            an_q   <= 4'b1111;
            seg_q  <= GLYPH_BLANK;
            dp_q   <= 1'b1;
        end else begin
            sc_q   <= sc_d;
            di_q   <= di_d;
            fc_q   <= fc_d;
            bp_q   <= bp_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with SCAN_DIV=4 and BLINK_FRAMES=2.
module tb_seg_scan;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [15:0] num_all;
    logic [1:0]  level;
    logic [2:0]  game_state;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entry: {check_seg, an[3:0], seg[6:0], dp}
    logic [12:0] exp_q[$];
    logic [12:0] e;
    logic [15:0] snap_m;

    always #5 clk = ~clk;

    seg_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .num3_disp  (num_all[15:12]),
        .num2_disp  (num_all[11:8]),
        .num1_disp  (num_all[7:4]),
        .num0_disp  (num_all[3:0]),
        .level      (level),
        .game_state (game_state),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    function automatic logic [6:0] ref_glyph(logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected outputs right after edge k (k=1 is the first edge after release).
    function automatic logic [12:0] exp_out(int k, logic [15:0] s, logic [1:0] lv, logic [2:0] gs);
        int         slot;
        logic       bp;
        logic [3:0] d;
        logic [3:0] a;
        logic [6:0] sg;
        logic       p;
        logic       chk;
        slot = ((k - 1) / SCAN_DIV) % 4;
        bp   = (((k - 1) / (FRAME * BLINK_FRAMES)) % 2) == 0;
        d    = s[slot*4 +: 4];
        a    = ~(4'b0001 << slot);
        sg   = ref_glyph(d);
        p    = (slot == int'(lv)) ? 1'b0 : 1'b1;
        chk  = 1'b1;
`ifdef SEG_LZB_EN
        if ((slot == 3 && s[15:12] == 0) ||
            (slot == 2 && s[15:8] == 0) ||
            (slot == 1 && s[15:4] == 0)) begin
            sg = 7'b1111111;
            if (slot != int'(lv)) begin
                a   = 4'b1111;
                chk = 1'b0;
            end
        end
`endif
        if (gs[1:0] == 2'b10 && !bp) begin
            a   = 4'b1111;
            p   = 1'b1;
            chk = 1'b0;
        end
        return {chk, a, sg, p};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr_n  = 1'b1;
        snap_m = 16'h0000;
    endtask

    task automatic test_reset();
        level      = 2'd1;
        game_state = 3'b001;
        num_all    = 16'h9876;
        do_reset();
        repeat (10) @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        n_checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        num_all = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            num_all = 16'($urandom_range(0, 65535));
            n_checks++;
            if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1", an, seg, dp);
            end
        end
        clr_n  = 1'b1;
        snap_m = 16'h0000;
        exp_q.push_back(13'b1_1110_1000000_1);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (an !== e[11:8] || seg !== e[7:1] || dp !== e[0]) begin
            n_fail++;
            $display("FAIL first_digit an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b", an, seg, dp, e[11:8], e[7:1], e[0]);
        end
    endtask

    task automatic test_scan_snapshot();
        level      = 2'd3;
        game_state = 3'b001;
        do_reset();
        num_all = 16'h1234;
        for (int k = 1; k <= 3 * FRAME; k++) begin
            exp_q.push_back(exp_out(k, snap_m, level, game_state));
            if (k % FRAME == 0) snap_m = num_all;
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (an !== e[11:8] || dp !== e[0] || (e[12] && seg !== e[7:1])) begin
                n_fail++;
                $display("FAIL scan k=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b", k, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if (k == FRAME + 5) num_all = 16'h5678;
        end
    endtask

    task automatic test_invalid_digit();
        level      = 2'd3;
        game_state = 3'b000;
        do_reset();
        num_all = 16'h7F0C;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            exp_q.push_back(exp_out(k, snap_m, level, game_state));
            if (k % FRAME == 0) snap_m = num_all;
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (an !== e[11:8] || dp !== e[0] || (e[12] && seg !== e[7:1])) begin
                n_fail++;
                $display("FAIL invalid k=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b", k, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_level_dp();
        level      = 2'd2;
        game_state = 3'b011;
        do_reset();
        num_all = 16'h2468;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            exp_q.push_back(exp_out(k, snap_m, level, game_state));
            if (k % FRAME == 0) snap_m = num_all;
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (an !== e[11:8] || dp !== e[0] || (e[12] && seg !== e[7:1])) begin
                n_fail++;
                $display("FAIL level_dp k=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b", k, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_blink();
        for (int pass = 0; pass < 2; pass++) begin
            level      = 2'd0;
            game_state = (pass == 0) ? 3'b010 : 3'b001;
            do_reset();
            num_all = 16'h0913;
            for (int k = 1; k <= 5 * FRAME; k++) begin
                exp_q.push_back(exp_out(k, snap_m, level, game_state));
                if (k % FRAME == 0) snap_m = num_all;
                @(posedge clk);
                @(negedge clk);
                e = exp_q.pop_front();
                n_checks++;
                if (an !== e[11:8] || dp !== e[0] || (e[12] && seg !== e[7:1])) begin
                    n_fail++;
                    $display("FAIL blink gs=%b k=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b", game_state, k, an, seg, dp, e[11:8], e[7:1], e[0]);
                end
            end
        end
    endtask

    task automatic test_gameover_midframe();
        level      = 2'd1;
        game_state = 3'b001;
        do_reset();
        num_all = 16'h3141;
        for (int k = 1; k <= 5 * FRAME; k++) begin
            exp_q.push_back(exp_out(k, snap_m, level, game_state));
            if (k % FRAME == 0) snap_m = num_all;
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (an !== e[11:8] || dp !== e[0] || (e[12] && seg !== e[7:1])) begin
                n_fail++;
                $display("FAIL go_midframe k=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b", k, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if (k == 2 * FRAME + 6) game_state = 3'b110;
        end
    endtask

    task automatic test_leading_zero();
        for (int pass = 0; pass < 2; pass++) begin
            level      = (pass == 0) ? 2'd3 : 2'd2;
            game_state = 3'b000;
            do_reset();
            num_all = 16'h0042;
            for (int k = 1; k <= 2 * FRAME; k++) begin
                exp_q.push_back(exp_out(k, snap_m, level, game_state));
                if (k % FRAME == 0) snap_m = num_all;
                @(posedge clk);
                @(negedge clk);
                e = exp_q.pop_front();
                n_checks++;
                if (an !== e[11:8] || dp !== e[0] || (e[12] && seg !== e[7:1])) begin
                    n_fail++;
                    $display("FAIL lzb lv=%0d k=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b", level, k, an, seg, dp, e[11:8], e[7:1], e[0]);
                end
            end
        end
    endtask

    task automatic test_random_digits();
        level      = 2'($urandom_range(0, 3));
        game_state = 3'b001;
        do_reset();
        num_all = 16'($urandom_range(0, 65535));
        for (int k = 1; k <= 4 * FRAME; k++) begin
            exp_q.push_back(exp_out(k, snap_m, level, game_state));
            if (k % FRAME == 0) snap_m = num_all;
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (an !== e[11:8] || dp !== e[0] || (e[12] && seg !== e[7:1])) begin
                n_fail++;
                $display("FAIL random k=%0d an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b", k, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if (k % 7 == 3) num_all = 16'($urandom_range(0, 65535));
        end
    endtask

    initial begin
        clr_n      = 1'b0;
        num_all    = 16'h0000;
        level      = 2'd0;
        game_state = 3'b000;
        snap_m     = 16'h0000;
        test_reset();
        test_scan_snapshot();
        test_invalid_digit();
        test_level_dp();
        test_blink();
        test_gameover_midframe();
        test_leading_zero();
        test_random_digits();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
